ex_div_unit: RTL and testbench
==============================

Name: ex_div_unit

Overview:
- Parametrised multi-cycle integer divider that serves DIV/DIVU for the EX stage. It is the next step after the two-stage MADD/MSUB multi-cycle path.
- EX raises start_i with latched operands and holds its stall request until ready_o pulses.
- The divider runs one restoring shift-subtract step per cycle and returns {remainder, quotient} for the HI/LO write.
- Operand width is generic, so the same block serves narrower test configurations.

Parameters:
- WIDTH, 32, operand width in bits (>=4). Result width is 2*WIDTH.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high; takes effect at the next rising edge of clk
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU)
- opdata1_i  in  WIDTH  dividend
- opdata2_i  in  WIDTH  divisor
- start_i  in  1  request; held high by EX until ready_o is seen
- annul_i  in  1  abort the current operation (branch-delay/flush)
- result_o  out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}
- ready_o  out  1  result valid
- div_zero_o  out  1  divisor was zero for the result being presented
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset:
  - state = IDLE, counter = 0.
  - result_o = 0, ready_o = 0, div_zero_o = 0, busy_o = 0.
  - Reset mid-operation abandons all work with no result.
- State IDLE:
  - If start_i=1 and annul_i=0, and opdata2_i==0: go to DIVZERO.
  - If start_i=1 and annul_i=0, and opdata2_i!=0: latch operands and go to RUN with counter = 0.
    - Latched values are |opdata1_i| and |opdata2_i| when signed_div_i=1 and the MSB is set; raw values otherwise.
    - Latch the sign flags: quotient negative = dividend sign XOR divisor sign (signed only); remainder negative = dividend sign (signed only).
  - Otherwise remain in IDLE.
- State RUN, one step per cycle, on a {partial_rem, dividend} register of width 2*WIDTH+1:
  - Shift the register left by 1.
  - Trial-subtract the divisor from the upper WIDTH+1 bits.
  - If the difference is non-negative, keep it and set the new quotient LSB to 1; else leave the register unchanged and set the LSB to 0.
  - Counter increments each step. After exactly WIDTH steps (the step with counter == WIDTH-1), go to DONE.
- State DIVZERO: next edge go to DONE with result_o = 0 and div_zero_o = 1.
- State DONE:
  - ready_o = 1. result_o = sign-corrected {remainder, quotient}; negation is two's complement at WIDTH bits.
  - Outputs are held while start_i stays high.
  - When start_i=0, or annul_i=1: go to IDLE next edge. result_o, ready_o and div_zero_o return to 0.
- Latency, counting from the edge that first samples start_i=1 in IDLE:
  - Normal divide: ready_o is high after WIDTH+1 edges.
  - Divide by zero: ready_o is high after 2 edges.
- annul_i in RUN or DIVZERO:
  - Go to IDLE at the next edge. ready_o never asserts for that operation.
  - annul_i has priority over completion on the same edge.
- start_i dropping during RUN does not abort the operation; only annul_i aborts.
- Operand changes after the launch edge are ignored.
- Signed most-negative / -1: quotient wraps to the most-negative value, remainder = 0. No exception.
- Divisor of 1, dividend 0, and dividend < divisor all take the full WIDTH-cycle latency. There is no early exit.
- All outputs are registered; none are combinational from inputs.

Test Plan:
- WIDTH=32, unsigned 100/7: start_i held high -> ready_o rises 33 edges after launch, result_o = {32'd2, 32'd14}, div_zero_o = 0. After start_i drops -> outputs 0 next edge.
- WIDTH=32, signed -7/2 (0xFFFFFFF9 / 0x2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Divisor 0 with dividend 0x12345678 -> ready_o after 2 edges, result_o = 0, div_zero_o = 1, busy_o high only during DIVZERO/DONE.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. Unsigned same operands -> quotient 0, remainder 0x80000000.
- annul_i pulsed 10 edges into RUN -> busy_o = 0 next edge, ready_o stays 0. An immediate new start for 9/3 -> {0, 3} at the normal latency. Separately, rst asserted mid-RUN -> all outputs 0 next edge.
- WIDTH=8 instance, unsigned 200/3 -> ready_o after 9 edges, result_o = {8'd2, 8'd66}. Signed 0x80/0xFF -> {8'h00, 8'h80}.

Source files
------------

// File: rtl/ex_div_unit.sv
// ex_div_unit: multi-cycle restoring integer divider for DIV/DIVU in EX.
//
// The divider takes one shift-subtract step per cycle on magnitudes. It
// fixes up the signs when the last step completes. The result comes back
// as {remainder, quotient} for the HI/LO write.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   signed_div_i  1 = DIV (signed), 0 = DIVU (unsigned)
//   opdata1_i     dividend, sampled on the launch edge only
//   opdata2_i     divisor, sampled on the launch edge only
//   start_i       request; EX holds it high until ready_o is seen
//   annul_i       abort the operation in flight (flush)
//   result_o      {remainder, quotient}, registered
//   ready_o       result valid, held while start_i stays high
//   div_zero_o    the presented result came from a zero divisor
//   busy_o        any state other than IDLE
module ex_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               div_zero_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_DIVZERO = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    // {partial remainder, dividend/quotient}. The extra top bit holds the
    // bit shifted out before the trial subtract.
    logic [2*WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     dsr_q, dsr_d;
    logic                 qneg_q, qneg_d;
    logic                 rneg_q, rneg_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;
    logic                 dz_q, dz_d;

    // Operand magnitudes at launch.
    logic                 op1_neg, op2_neg;
    logic [WIDTH-1:0]     op1_abs, op2_abs;

    assign op1_neg = signed_div_i & opdata1_i[WIDTH-1];
    assign op2_neg = signed_div_i & opdata2_i[WIDTH-1];
    assign op1_abs = op1_neg ? -opdata1_i : opdata1_i;
    assign op2_abs = op2_neg ? -opdata2_i : opdata2_i;

    // One restoring step.
    logic [2*WIDTH:0]     shifted;
    logic [WIDTH:0]       trial;
    logic [2*WIDTH:0]     step_acc;
    logic [WIDTH-1:0]     fin_q, fin_r, fix_q, fix_r;
    logic                 last_step;
    logic                 unused_top;

    always_comb begin
        shifted = acc_q << 1;
        trial   = shifted[2*WIDTH:WIDTH];
        if (trial >= {1'b0, dsr_q}) begin
            step_acc = {trial - {1'b0, dsr_q}, shifted[WIDTH-1:1], 1'b1};
        end else begin
            step_acc = shifted;
        end
    end

    // The remainder is always below the divisor, so it fits in WIDTH bits.
    // The top bit of the step result is always zero.
    assign fin_q      = step_acc[WIDTH-1:0];
    assign fin_r      = step_acc[2*WIDTH-1:WIDTH];
    assign unused_top = step_acc[2*WIDTH];
    // The negation wraps at WIDTH bits. For most-negative / -1 the quotient
    // therefore stays at the most-negative value.
    assign fix_q      = qneg_q ? -fin_q : fin_q;
    assign fix_r      = rneg_q ? -fin_r : fin_r;
    assign last_step  = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        dsr_d    = dsr_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        ready_d  = ready_q;
        dz_d     = dz_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = S_DIVZERO;
                    end else begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        acc_d   = {{(WIDTH + 1){1'b0}}, op1_abs};
                        dsr_d   = op2_abs;
                        qneg_d  = op1_neg ^ op2_neg;
                        rneg_d  = op1_neg;
                    end
                end
            end
            S_RUN: begin
                // The abort wins over a completion on the same edge.
                if (annul_i) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = step_acc;
                    cnt_d = cnt_q + 1'b1;
                    if (last_step) begin
                        state_d  = S_DONE;
                        result_d = {fix_r, fix_q};
                        ready_d  = 1'b1;
                        dz_d     = 1'b0;
                    end
                end
            end
            S_DIVZERO: begin
                if (annul_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_DONE;
                    result_d = '0;
                    ready_d  = 1'b1;
                    dz_d     = 1'b1;
                end
            end
            S_DONE: begin
                if (!start_i || annul_i) begin
                    state_d  = S_IDLE;
                    result_d = '0;
                    ready_d  = 1'b0;
                    dz_d     = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            dsr_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            dsr_q    <= dsr_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            dz_q     <= dz_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign div_zero_o = dz_q;
    assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_ex_div_unit.sv
// Bench for ex_div_unit: a 32-bit instance and an 8-bit instance.
// It applies a table of directed vectors and a set of hand-written abort
// and reset sequences. It then runs random operands against a plain
// arithmetic reference.
module tb_ex_div_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        s32 = 0, st32 = 0, an32 = 0;
    logic [31:0] a32 = 0, b32 = 0;
    logic [63:0] res32;
    logic        rdy32, dz32, bsy32;

    logic        s8 = 0, st8 = 0, an8 = 0;
    logic [7:0]  a8 = 0, b8 = 0;
    logic [15:0] res8;
    logic        rdy8, dz8, bsy8;

    ex_div_unit #(.WIDTH(32), .CNT_W(6)) dut32 (
        .clk(clk), .rst(rst), .signed_div_i(s32), .opdata1_i(a32), .opdata2_i(b32),
        .start_i(st32), .annul_i(an32), .result_o(res32), .ready_o(rdy32),
        .div_zero_o(dz32), .busy_o(bsy32));

    ex_div_unit #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk(clk), .rst(rst), .signed_div_i(s8), .opdata1_i(a8), .opdata2_i(b8),
        .start_i(st8), .annul_i(an8), .result_o(res8), .ready_o(rdy8),
        .div_zero_o(dz8), .busy_o(bsy8));

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference: the arithmetic meaning of DIV/DIVU at width w, computed in
    // 64-bit so that no operand combination can overflow.
    task automatic model(input int w, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint m, av, bv, qv, rv;
        m  = (longint'(1) << w) - 1;
        av = {32'b0, a} & m;
        bv = {32'b0, b} & m;
        if (sgn && av[w-1]) av = av - (longint'(1) << w);
        if (sgn && bv[w-1]) bv = bv - (longint'(1) << w);
        if (bv == 0) begin
            q = 0; r = 0; dz = 1'b1;
        end else begin
            qv = av / bv;
            rv = av % bv;
            q  = qv[31:0] & m[31:0];
            r  = rv[31:0] & m[31:0];
            dz = 1'b0;
        end
    endtask

    // Run one full operation on the 32-bit instance with start held through
    // the result. Scramble the operands after launch, then release start.
    task automatic op32(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz, input int elat);
        int lat = 0;
        logic busy_ok = 1'b1;
        @(negedge clk);
        s32 = sgn; a32 = a; b32 = b; st32 = 1'b1;
        do begin
            @(posedge clk); #1;
            lat++;
            if (!bsy32) busy_ok = 1'b0;
            if (lat == 1) begin a32 = $urandom; b32 = $urandom; end
        end while (!rdy32 && lat < 100);
        chk({tag, " latency"}, 64'(lat), 64'(elat));
        chk({tag, " result"}, res32, {er, eq});
        chk({tag, " div_zero"}, 64'(dz32), 64'(edz));
        chk({tag, " busy"}, 64'(busy_ok), 64'd1);
        @(posedge clk); #1;
        chk({tag, " hold"}, {rdy32, res32}, {1'b1, er, eq});
        @(negedge clk); st32 = 1'b0;
        @(posedge clk); #1;
        chk({tag, " release"}, {60'd0, rdy32, dz32, bsy32, |res32}, 64'd0);
    endtask

    task automatic op8(input string tag, input logic sgn, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er, input logic edz, input int elat);
        int lat = 0;
        @(negedge clk);
        s8 = sgn; a8 = a; b8 = b; st8 = 1'b1;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin a8 = 8'($urandom); b8 = 8'($urandom); end
        end while (!rdy8 && lat < 100);
        chk({tag, " latency"}, 64'(lat), 64'(elat));
        chk({tag, " result"}, 64'(res8), 64'({er, eq}));
        chk({tag, " div_zero"}, 64'(dz8), 64'(edz));
        @(negedge clk); st8 = 1'b0;
        @(posedge clk); #1;
        chk({tag, " release"}, {61'd0, rdy8, bsy8, |res8}, 64'd0);
    endtask

    typedef struct {
        logic        sgn;
        logic [31:0] a, b, q, r;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [31:0] ra, rb, mq, mr;
        logic        rs, mdz;
        int          lat;
        logic        seen;

        tbl[0]  = '{0, 32'd100,        32'd7,          32'd14,         32'd2,          0, 33};
        tbl[1]  = '{1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   0, 33};
        tbl[2]  = '{1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          0, 33};
        tbl[3]  = '{0, 32'h12345678,   32'd0,          32'd0,          32'd0,          1, 2};
        tbl[4]  = '{1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          0, 33};
        tbl[5]  = '{0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   0, 33};
        tbl[6]  = '{0, 32'd9,          32'd3,          32'd3,          32'd0,          0, 33};
        tbl[7]  = '{0, 32'd0,          32'd5,          32'd0,          32'd0,          0, 33};
        tbl[8]  = '{0, 32'd3,          32'd10,         32'd0,          32'd3,          0, 33};
        tbl[9]  = '{1, 32'hFFFFFFF0,   32'd1,          32'hFFFFFFF0,   32'd0,          0, 33};
        tbl[10] = '{1, 32'h80000000,   32'd0,          32'd0,          32'd0,          1, 2};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset32", {60'd0, rdy32, dz32, bsy32, |res32}, 64'd0);
        chk("reset8", {60'd0, rdy8, dz8, bsy8, |res8}, 64'd0);
        rst = 1'b0;

        foreach (tbl[i])
            op32($sformatf("vec%0d", i), tbl[i].sgn, tbl[i].a, tbl[i].b,
                 tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].lat);

        // Annul 10 edges into the run, then an immediate new 9/3.
        @(negedge clk);
        s32 = 0; a32 = 32'd1000; b32 = 32'd7; st32 = 1'b1;
        seen = 1'b0;
        repeat (10) begin @(posedge clk); #1; if (rdy32) seen = 1'b1; end
        an32 = 1'b1;
        @(posedge clk); #1;
        if (rdy32) seen = 1'b1;
        chk("annul busy", 64'(bsy32), 64'd0);
        chk("annul no ready", 64'(seen), 64'd0);
        an32 = 1'b0;
        op32("after annul", 0, 32'd9, 32'd3, 32'd3, 32'd0, 0, 33);

        // Annul while in DIVZERO.
        @(negedge clk);
        s32 = 0; a32 = 32'd5; b32 = 32'd0; st32 = 1'b1;
        @(posedge clk); #1;
        an32 = 1'b1;
        @(posedge clk); #1;
        chk("annul dz", {61'd0, rdy32, dz32, bsy32}, 64'd0);
        an32 = 1'b0; st32 = 1'b0;

        // An annul that arrives together with start in IDLE does not launch.
        @(negedge clk);
        a32 = 32'd5; b32 = 32'd1; st32 = 1'b1; an32 = 1'b1;
        @(posedge clk); #1;
        chk("annul idle", 64'(bsy32), 64'd0);
        st32 = 1'b0; an32 = 1'b0;

        // Reset mid-run.
        @(negedge clk);
        s32 = 1; a32 = 32'hDEADBEEF; b32 = 32'd13; st32 = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst mid-run", {60'd0, rdy32, dz32, bsy32, |res32}, 64'd0);
        rst = 1'b0; st32 = 1'b0;

        // Start dropping during the run does not abort the operation.
        @(negedge clk);
        s32 = 0; a32 = 32'd1000; b32 = 32'd7; st32 = 1'b1;
        @(posedge clk); #1;
        st32 = 1'b0;
        lat = 1;
        do begin @(posedge clk); #1; lat++; end while (!rdy32 && lat < 100);
        chk("drop latency", 64'(lat), 64'd33);
        chk("drop result", res32, {32'd6, 32'd142});
        @(posedge clk); #1;
        chk("drop release", {62'd0, rdy32, bsy32}, 64'd0);

        // Random 32-bit operands.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            rs = 1'($urandom_range(0, 1));
            model(32, rs, ra, rb, mq, mr, mdz);
            op32($sformatf("rnd32_%0d", i), rs, ra, rb, mq, mr, mdz, mdz ? 2 : 33);
        end

        // 8-bit instance
        op8("w8 200/3", 0, 8'd200, 8'd3, 8'd66, 8'd2, 0, 9);
        op8("w8 80/FF", 1, 8'h80, 8'hFF, 8'h80, 8'h00, 0, 9);
        op8("w8 dz", 1, 8'h42, 8'h00, 8'h00, 8'h00, 1, 2);
        for (int i = 0; i < 30; i++) begin
            ra = 32'($urandom_range(0, 255));
            rb = (i % 7 == 0) ? 32'd0 : 32'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            model(8, rs, ra, rb, mq, mr, mdz);
            op8($sformatf("rnd8_%0d", i), rs, ra[7:0], rb[7:0], mq[7:0], mr[7:0], mdz, mdz ? 2 : 9);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
